// File: rtl/riscv_pkg.sv
// +--------------------------------------------------------------------+
// | riscv_pkg : shared widths, constants and fetch entry type          |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam int          ILEN             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// +--------------------------------------------------------------------+
// | fetch_queue : synchronous FIFO of fetch entries with flush         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    // DEPTH is a power of two, so pointer overflow gives the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// +--------------------------------------------------------------------+
// | ifu_fetch : PC owner, imem driver and fetch queue to decode        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module ifu_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    logic [31:0]  r_pc;
    logic         w_full;
    logic         w_empty;
    logic         w_deq;
    logic         w_fetch;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;

    assign out_valid = ~w_empty & ~redirect_valid;
    assign w_deq     = out_valid & out_ready;
    assign w_fetch   = ~redirect_valid & (~w_full | w_deq);

    // Redirect target alignment bits are discarded; execute owns misalignment traps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc & ~32'h0000_0003;
        end else if (w_fetch) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign imem_addr     = r_pc;
    assign w_entry.pc    = r_pc;
    assign w_entry.instr = imem_data;

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fetch),
        .i_pop   (w_deq),
        .i_flush (redirect_valid),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// +--------------------------------------------------------------------+
// | tb_ifu_fetch : directed + random stimulus against a queue model    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ifu_fetch;
    import riscv_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam int          TB_QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]  m_pc;
    fetch_entry_t mq[$];

    always #5 clk = ~clk;

    // Word i holds 0x1000+i; the top 64 KiB reads as NOPs.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a[31:16] == 16'hFFFF) return INSTR_NOP;
        return 32'h0000_1000 + {2'b00, a[31:2]};
    endfunction

    assign imem_data = imem_word(imem_addr);

    ifu_fetch #(
        .RESET_PC (TB_RESET_PC),
        .QDEPTH   (TB_QDEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = TB_RESET_PC;
        mq.delete();
    endtask

    // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic         exp_v;
        logic         deq;
        logic         fetch_ok;
        fetch_entry_t e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #3;
        exp_v = (mq.size() != 0) && !rv;
        check("imem_addr", imem_addr, m_pc);
        check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
        if (exp_v) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_instr", out_instr, mq[0].instr);
        end
        @(posedge clk);
        if (rv) begin
            mq.delete();
            m_pc = rpc & ~32'h0000_0003;
        end else begin
            deq      = exp_v && rdy;
            fetch_ok = (mq.size() < TB_QDEPTH) || deq;
            if (deq) void'(mq.pop_front());
            if (fetch_ok) begin
                e.pc    = m_pc;
                e.instr = imem_word(m_pc);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        logic        rv;
        logic        rdy;
        logic [31:0] rpc;

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_imem_addr", imem_addr, TB_RESET_PC);
        rst_n = 1'b1;
        model_reset();

        // Streaming, stall, release
        repeat (8) cycle(1'b0, 32'h0, 1'b1);
        repeat (5) cycle(1'b0, 32'h0, 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);

        // Redirect while full, then back-to-back redirects
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0102, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'h0000_0200, 1'b1);
        cycle(1'b1, 32'h0000_0300, 1'b1);
        repeat (4) cycle(1'b0, 32'h0, 1'b1);

        // PC wrap through 0xFFFF_FFFC
        cycle(1'b1, 32'hFFFF_FFF0, 1'b1);
        repeat (8) cycle(1'b0, 32'h0, 1'b1);

        // Async reset while the queue is full
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        #2;
        check("pre_rst_valid", {31'b0, out_valid}, {31'b0, (mq.size() != 0)});
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_addr", imem_addr, TB_RESET_PC);
        check("async_rst_pc", out_pc, 32'd0);
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (4) cycle(1'b0, 32'h0, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rv  = ($urandom % 10) == 0;
            rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFE0 | ($urandom % 32))
                                        : ($urandom % 4096);
            rdy = ($urandom % 4) != 0;
            cycle(rv, rpc, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
